// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer with one-shot/auto-reload modes and a maskable interrupt.
module timer_device (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        IRQ
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t state, state_nxt;
  logic [3:0] ctrl;
  logic [31:0] preset, count;
  logic pending;
  logic enable, auto_reload, wr_ctrl, wr_preset;
  logic do_load, do_dec, do_set, do_int_os, do_int_ar;
  assign enable      = ctrl[0];
  assign auto_reload = ctrl[2:1] == 2'b01;
  assign wr_ctrl     = We && Addr == 2'b00;
  assign wr_preset   = We && Addr == 2'b01;
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? (enable ? LOAD : IDLE) :
                state == LOAD ? CNT :
                state == CNT  ? (!enable ? IDLE : count == 32'd0 ? INT : CNT) :
                                (auto_reload ? LOAD : IDLE);
  always_comb begin
    do_load   = state == LOAD;
    do_dec    = state == CNT && enable && count != 32'd0;
    do_set    = state == CNT && enable && count == 32'd0;
    do_int_os = state == INT && !auto_reload;
    do_int_ar = state == INT && auto_reload;
  end
  // A CTRL write beats the one-shot Enable clear; a fresh expiry beats a pending clear.
  always_ff @(posedge clk)
    if (!reset) begin
      ctrl    <= 4'd0;
      preset  <= 32'd0;
      count   <= 32'd0;
      pending <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= DataIn[3:0];
      else if (do_int_os) ctrl[0] <= 1'b0;
      if (wr_preset) preset <= DataIn;
      if (do_load) count <= preset;
      else if (do_dec) count <= count - 32'd1;
      if (do_set) pending <= 1'b1;
      else if (do_int_ar || (wr_ctrl && !auto_reload)) pending <= 1'b0;
    end
  always_comb
    DataOut = Addr == 2'b00 ? {28'd0, ctrl} :
              Addr == 2'b01 ? preset :
              Addr == 2'b10 ? count : 32'd0;
  assign IRQ = pending & ctrl[3];
endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: directed scenarios plus random traffic, checked against a behavioural timer model.
module tb_timer_device;
  logic clk, reset, We, IRQ;
  logic [1:0] Addr;
  logic [31:0] DataIn, DataOut;
  int checks, failures;
  bit armed;
  logic [3:0] m_ctrl;
  logic [31:0] m_preset, m_count;
  logic m_pend;
  int m_ph;

  timer_device dut (
    .clk(clk), .reset(reset), .Addr(Addr), .We(We),
    .DataIn(DataIn), .DataOut(DataOut), .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    return a == 2'd0 ? {28'd0, m_ctrl} : a == 2'd1 ? m_preset : a == 2'd2 ? m_count : 32'd0;
  endfunction

  // Phases of a timer run: 0 idle, 1 reloading, 2 counting down, 3 expired.
  task automatic model_step(input logic r, input logic [1:0] a, input logic w, input logic [31:0] d);
    logic [3:0] c;
    logic [31:0] n;
    logic p, ar, fire;
    int ph;
    if (!r) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_pend = 1'b0; m_ph = 0;
      return;
    end
    c = m_ctrl; n = m_count; p = m_pend; ph = m_ph;
    ar = m_ctrl[2:1] == 2'b01;
    fire = 1'b0;
    if (m_ph == 0) ph = m_ctrl[0] ? 1 : 0;
    else if (m_ph == 1) begin n = m_preset; ph = 2; end
    else if (m_ph == 2) begin
      if (!m_ctrl[0]) ph = 0;
      else if (m_count == 32'd0) begin ph = 3; p = 1'b1; fire = 1'b1; end
      else n = m_count - 32'd1;
    end
    else if (ar) begin p = 1'b0; ph = 1; end
    else begin c[0] = 1'b0; ph = 0; end
    if (w && a == 2'd1) m_preset = d;
    if (w && a == 2'd0) begin
      c = d[3:0];
      if (!ar && !fire) p = 1'b0;
    end
    m_ctrl = c; m_count = n; m_pend = p; m_ph = ph;
  endtask

  task automatic cyc(input logic r, input logic [1:0] a, input logic w, input logic [31:0] d);
    reset = r; Addr = a; We = w; DataIn = d;
    @(negedge clk);
    if (armed) begin
      chk("model_read", DataOut, model_rd(a));
      chk("model_irq", {31'd0, IRQ}, {31'd0, m_pend & m_ctrl[3]});
    end
    @(posedge clk);
    model_step(r, a, w, d);
    armed = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 2'd2, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, a, 1'b1, d);
  endtask

  task automatic rst();
    cyc(1'b0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
    Addr = a; We = 1'b0;
    #1;
    chk(tag, DataOut, exp);
  endtask

  task automatic irq_is(input string tag, input logic e);
    chk(tag, {31'd0, IRQ}, {31'd0, e});
  endtask

  initial begin
    checks = 0; failures = 0; armed = 1'b0;
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_pend = 1'b0; m_ph = 0;
    reset = 1'b0; Addr = 2'd0; We = 1'b0; DataIn = 32'd0;
    // reset overrides a simultaneous write
    rst();
    cyc(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF);
    cyc(1'b0, 2'd0, 1'b1, 32'hF);
    for (int a = 0; a < 4; a++) peek("reset_read", 2'(a), 32'd0);
    irq_is("reset_irq", 1'b0);
    idle(1);
    // writes to COUNT and reserved are ignored
    wr(2'd2, 32'h1234);
    wr(2'd3, 32'h5678);
    peek("count_ro", 2'd2, 32'd0);
    peek("reserved", 2'd3, 32'd0);
    peek("ctrl_zext", 2'd0, 32'd0);

    // one-shot timing
    wr(2'd1, 32'd3);
    peek("preset_rd", 2'd1, 32'd3);
    wr(2'd0, 32'h9);
    idle(1);
    peek("os_load_cnt_old", 2'd2, 32'd0);
    idle(1); peek("os_cnt3", 2'd2, 32'd3);
    idle(1); peek("os_cnt2", 2'd2, 32'd2);
    idle(1); peek("os_cnt1", 2'd2, 32'd1);
    idle(1); peek("os_cnt0", 2'd2, 32'd0);
    irq_is("os_irq_edge5", 1'b0);
    idle(1); irq_is("os_irq_edge6", 1'b1);
    idle(1); peek("os_enable_cleared", 2'd0, 32'h8);
    idle(4); irq_is("os_irq_sticky", 1'b1);
    peek("os_cnt_hold", 2'd2, 32'd0);
    wr(2'd1, 32'd7); irq_is("os_preset_no_clear", 1'b1);
    wr(2'd0, 32'h8); irq_is("os_ctrl_clears", 1'b0);

    // auto-reload: pulse every PRESET+3 cycles
    rst();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      idle(1);
      irq_is("ar_pulse", k >= 5 && (k - 5) % 5 == 0);
    end

    // masked one-shot
    rst();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      irq_is("mask_irq", 1'b0);
    end
    peek("mask_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    irq_is("mask_cleared", 1'b0);
    idle(2); irq_is("mask_cleared2", 1'b0);

    // pause and reload
    rst();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    idle(4);
    peek("pause_cnt8", 2'd2, 32'd8);
    wr(2'd0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      peek("pause_hold7", 2'd2, 32'd7);
      idle(1);
    end
    wr(2'd0, 32'h1);
    idle(1); peek("resume_load_edge", 2'd2, 32'd7);
    idle(1); peek("resume_reload10", 2'd2, 32'd10);

    // PRESET write mid-count
    rst();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    idle(3);
    peek("coll_cnt2", 2'd2, 32'd2);
    wr(2'd1, 32'd5);
    peek("coll_cnt1", 2'd2, 32'd1);
    idle(1); irq_is("coll_irq_e5", 1'b0);
    idle(1); irq_is("coll_irq_e6", 1'b1);
    idle(1); irq_is("coll_irq_e7", 1'b0);
    idle(1); peek("coll_reload5", 2'd2, 32'd5);

    // CTRL write in the INT cycle keeps Enable
    rst();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    idle(4);
    irq_is("int_irq", 1'b1);
    wr(2'd0, 32'h9);
    peek("int_ctrl_kept", 2'd0, 32'h9);
    irq_is("int_pend_cleared", 1'b0);
    idle(2); peek("int_restart", 2'd2, 32'd1);

    // reset mid-count
    rst();
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    idle(4);
    peek("mid_cnt4", 2'd2, 32'd4);
    rst();
    for (int a = 0; a < 4; a++) peek("mid_reset_read", 2'(a), 32'd0);
    for (int k = 0; k < 10; k++) begin
      idle(1);
      irq_is("mid_reset_irq", 1'b0);
    end
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    idle(2); peek("mid_idle_restart", 2'd2, 32'd2);

    // random traffic against the model
    rst();
    for (int k = 0; k < 600; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) rst();
      else if (r < 10) wr(2'd0, {28'd0, 4'($urandom)});
      else if (r < 16) wr(2'd1, 32'($urandom_range(0, 8)));
      else if (r < 19) wr(2'($urandom_range(2, 3)), $urandom);
      else cyc(1'b1, 2'($urandom), 1'b0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
